// File: rtl/serial_byte_assembler_if.sv
// Bus bundle for serial_byte_assembler: serial bit stream in, parallel word out with
// valid/ready handshake and the overrun and frame-error pulses.
interface serial_byte_assembler_if #(
    parameter int unsigned WIDTH = 8
);
    logic             bit_in;
    logic             bit_valid;
    logic             frame_start;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             data_ready;
    logic             overrun;
    logic             frame_err;

    // Upstream bit source and downstream consumer side
    modport master (
        output bit_in, bit_valid, frame_start, data_ready,
        input  data_out, data_valid, overrun, frame_err
    );

    // Assembler side
    modport slave (
        input  bit_in, bit_valid, frame_start, data_ready,
        output data_out, data_valid, overrun, frame_err
    );
endinterface

// File: rtl/serial_byte_assembler.sv
// Deserializes a framed serial bit stream into WIDTH-bit words, double-buffered:
// the shift register collects the next word while the output register holds the current one.
module serial_byte_assembler #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    serial_byte_assembler_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [WIDTH-1:0]   shreg, shreg_n;
    logic [WIDTH-1:0]   data_q, data_n;
    logic               valid_q, valid_n;
    logic               ovr_q, ovr_n;
    logic               ferr_q, ferr_n;
    logic               word_done;
    logic [WIDTH-1:0]   word;

    // New bit enters at the LSB for MSB-first streams, at the MSB otherwise
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
        if (MSB_FIRST) return {cur[WIDTH-2:0], b};
        else           return {b, cur[WIDTH-1:1]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            shreg   <= shreg_n;
            data_q  <= data_n;
            valid_q <= valid_n;
            ovr_q   <= ovr_n;
            ferr_q  <= ferr_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        shreg_n   = shreg;
        data_n    = data_q;
        valid_n   = valid_q & ~bus.data_ready;
        ovr_n     = 1'b0;
        ferr_n    = 1'b0;
        word_done = 1'b0;
        word      = shift_in(shreg, bus.bit_in);

        unique case (state)
            IDLE: begin
                if (bus.bit_valid && bus.frame_start) begin
                    shreg_n = shift_in('0, bus.bit_in);
                    cnt_n   = CNT_W'(1);
                    state_n = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.bit_valid) begin
                    if (bus.frame_start) begin
                        // Early frame start: drop the partial word, restart with this bit
                        ferr_n  = 1'b1;
                        shreg_n = shift_in('0, bus.bit_in);
                        cnt_n   = CNT_W'(1);
                    end else if (cnt == CNT_W'(WIDTH - 1)) begin
                        shreg_n   = word;
                        word_done = 1'b1;
                        cnt_n     = '0;
                        state_n   = IDLE;
                    end else begin
                        shreg_n = word;
                        cnt_n   = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Output register accepts a completed word if empty or being drained this edge
        if (word_done) begin
            if (!valid_q || bus.data_ready) begin
                data_n  = word;
                valid_n = 1'b1;
            end else begin
                ovr_n = 1'b1;
            end
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.overrun    = ovr_q;
    assign bus.frame_err  = ferr_q;
endmodule

// File: doc/serial_byte_assembler.md
Name: serial_byte_assembler

Overview:
- Upstream stage of the palindrome detector: deserializes a framed serial bit stream into WIDTH-bit words and presents each word on a registered parallel output with valid/ready handshake.
- data_out drives the detector's data_in directly; data_valid/data_ready let a downstream controller pace word consumption.
- Double-buffered: shift register collects the next word while the output register holds the current one.

Parameters:
- WIDTH, 8, word width in bits (>=2)
- MSB_FIRST, 1, 1 = first serial bit lands in data_out[WIDTH-1]; 0 = first bit lands in data_out[0]

Ports:
- clk  input  1  system clock, all logic rising-edge
- rst_n  input  1  asynchronous active-low reset
- bit_in  input  1  serial data bit
- bit_valid  input  1  bit_in is sampled this cycle
- frame_start  input  1  marks the current bit_in as bit 0 of a new word; only meaningful with bit_valid=1
- data_out  output  WIDTH  assembled word, registered
- data_valid  output  1  data_out holds an unconsumed word
- data_ready  input  1  consumer accepts data_out this cycle
- overrun  output  1  one-cycle pulse: completed word dropped because output register full
- frame_err  output  1  one-cycle pulse: partial word discarded by early frame_start

Behaviour:
- Reset (async, rst_n=0): data_out=0, data_valid=0, overrun=0, frame_err=0, shift reg=0, bit count=0, collector FSM=IDLE. Release is synchronous in effect; first sampling edge is the first rising clk with rst_n=1.
- Collector FSM states: IDLE, COLLECT.
  - IDLE: bit_valid without frame_start ignored. bit_valid & frame_start -> load bit as bit 0, count=1, go COLLECT.
  - COLLECT: bit_valid & ~frame_start -> shift bit in, count+1. bit_valid & frame_start -> frame_err pulse next cycle, partial discarded, bit taken as new bit 0, count=1, stay COLLECT.
  - Word completes on the edge sampling bit WIDTH-1 (count reaches WIDTH): collector returns to IDLE, count=0.
- Bit placement: MSB_FIRST=1 shifts left (new bit into LSB, first bit ends in MSB); MSB_FIRST=0 shifts right (new bit into MSB, first bit ends in LSB).
- Transfer to output: on completion edge, if data_valid=0, or data_valid=1 & data_ready=1 in the same cycle, data_out <= completed word and data_valid=1 next cycle. Latency: data_valid rises one clock after the edge sampling the last bit.
- If data_valid=1 & data_ready=0 on completion edge: word dropped, data_out unchanged, overrun pulses 1 cycle.
- Handshake: transfer when data_valid & data_ready at a rising edge. data_valid clears next cycle unless a new word loads on that same edge. data_out stays stable while data_valid=1 and retains last value after consumption.
- data_ready while data_valid=0 has no effect.
- Back-to-back words (frame_start on the cycle after completion) supported with zero idle cycles; sustained throughput one word per WIDTH bit-valid cycles.
- bit_valid=0 cycles are stalls: count and shift reg hold, no timeout.
- Reset mid-word or mid-hold: all state cleared immediately; partial and held words lost, no error pulses.
- Bit count width = clog2(WIDTH+1).

Test Plan:
- Reset: rst_n low mid-COLLECT after 3 bits -> data_valid=0, data_out=0 asynchronously; next frame 8'b11001101 assembles correctly with data_ready=1.
- MSB_FIRST=1: stream 1,1,0,1,1,0,1,1 with frame_start on the first bit, bit_valid continuous, data_ready=1 -> data_out=8'b11011011, data_valid high exactly one cycle after the 8th bit; MSB_FIRST=0 same stream -> 8'b11011011 (symmetric), then stream 0,0,0,0,1,1,1,1 -> 8'b11110000.
- Back-to-back: words 8'b00111100 then 8'b10101010 with no gap, data_ready=1 -> two consecutive data_valid windows, correct values, no overrun.
- Backpressure: data_ready=0, send 8'b11110000 then 8'b10101010 -> data_out holds 8'b11110000, overrun pulses once at end of the second word; raise data_ready -> data_valid drops next cycle.
- Early frame_start: after 5 bits, assert frame_start with a new word 8'b11001101 -> frame_err single pulse; output 8'b11001101 only.
- Stalls: same word with random bit_valid gaps -> identical data_out and count as contiguous case.
